// File: rtl/bus_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_master_arbiter
// Purpose  : Shares one AHB-Lite master port between a data port (0) and an
//            instruction-fetch port (1); one transfer in flight at a time.
// Revision : 1.0
// ============================================================================
module bus_master_arbiter #(
    parameter int MAX_CONSEC = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic        req0_write,
    input  logic [1:0]  req0_size,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp0_error,

    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic        req1_write,
    input  logic [1:0]  req1_size,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        rsp1_error,

    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] C_MAX_CONSEC = 4'(MAX_CONSEC);
    localparam logic [1:0] C_IDLE       = 2'b00;
    localparam logic [1:0] C_NONSEQ     = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        req0_ready_q, req0_ready_d;
    logic        req1_ready_q, req1_ready_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp0_data_q, rsp0_data_d;
    logic [31:0] rsp1_data_q, rsp1_data_d;
    logic        rsp0_error_q, rsp0_error_d;
    logic        rsp1_error_q, rsp1_error_d;
    logic        grant1;
    logic [31:0] rsp_data;

    // Fetch wins when it is alone, or when data has starved it long enough.
    assign grant1   = req1_valid && (!req0_valid || (starve_q == C_MAX_CONSEC));
    assign rsp_data = (hresp || hwrite_q) ? 32'd0 : hrdata;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        sel_d        = sel_q;
        wdata_d      = wdata_q;
        haddr_d      = haddr_q;
        htrans_d     = htrans_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        hwdata_d     = hwdata_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = 32'd0;
        rsp1_data_d  = 32'd0;
        rsp0_error_d = 1'b0;
        rsp1_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                htrans_d = C_IDLE;
                if (req0_valid || req1_valid) begin
                    sel_d    = grant1;
                    haddr_d  = grant1 ? req1_addr : req0_addr;
                    hwrite_d = grant1 ? req1_write : req0_write;
                    hsize_d  = {1'b0, (grant1 ? req1_size : req0_size)};
                    wdata_d  = grant1 ? req1_wdata : req0_wdata;
                    htrans_d = C_NONSEQ;
                    req0_ready_d = !grant1;
                    req1_ready_d = grant1;
                    state_d  = ADDR;
                    if (grant1 || !req1_valid) begin
                        starve_d = 4'd0;
                    end else if (starve_q != C_MAX_CONSEC) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ADDR: begin
                if (hready) begin
                    htrans_d = C_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = DATA;
                end
            end
            DATA: begin
                // hresp is only meaningful on the completing (hready) cycle.
                if (hready) begin
                    rsp0_valid_d = !sel_q;
                    rsp1_valid_d = sel_q;
                    rsp0_error_d = !sel_q && hresp;
                    rsp1_error_d = sel_q && hresp;
                    rsp0_data_d  = sel_q ? 32'd0 : rsp_data;
                    rsp1_data_d  = sel_q ? rsp_data : 32'd0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                htrans_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_q     <= 4'd0;
            sel_q        <= 1'b0;
            wdata_q      <= 32'd0;
            haddr_q      <= 32'd0;
            htrans_q     <= C_IDLE;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'd0;
            hwdata_q     <= 32'd0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 32'd0;
            rsp1_data_q  <= 32'd0;
            rsp0_error_q <= 1'b0;
            rsp1_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            sel_q        <= sel_d;
            wdata_q      <= wdata_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            hwdata_q     <= hwdata_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp0_error_q <= rsp0_error_d;
            rsp1_error_q <= rsp1_error_d;
        end
    end

    assign haddr      = haddr_q;
    assign htrans     = htrans_q;
    assign hwrite     = hwrite_q;
    assign hsize      = hsize_q;
    assign hwdata     = hwdata_q;
    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp0_error = rsp0_error_q;
    assign rsp1_error = rsp1_error_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_master_arbiter
// Purpose  : Directed scoreboard bench for bus_master_arbiter.
// Revision : 1.0
// ============================================================================
module tb_bus_master_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_error;
    logic [31:0] req0_addr, req0_wdata, rsp0_data;
    logic [1:0]  req0_size;
    logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_error;
    logic [31:0] req1_addr, req1_wdata, rsp1_data;
    logic [1:0]  req1_size;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize;

    logic        auto_slave;
    logic [31:0] man_rdata;
    logic [31:0] dp_addr = 32'd0;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int rsp1_cnt = 0;

    always #5 clock = ~clock;

    bus_master_arbiter #(.MAX_CONSEC(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_write(req0_write),
        .req0_size(req0_size), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_error(rsp0_error),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_write(req1_write),
        .req1_size(req1_size), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_error(rsp1_error),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    // Simple slave: remembers the address accepted into the data phase.
    always @(posedge clock) begin
        if (htrans == 2'b10 && hready) dp_addr <= haddr;
    end
    assign hrdata = auto_slave ? (dp_addr ^ 32'hCAFE_0000) : man_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_rsp(input logic port, input logic [31:0] data, input logic err);
        exp_t e;
        if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(port), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("rsp_port", 32'(port), 32'(e.port));
            chk("rsp_data", data, e.data);
            chk("rsp_error", 32'(err), 32'(e.err));
        end
    endtask

    always begin
        @(posedge clock);
        #2;
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
            if (rsp0_valid) check_rsp(1'b0, rsp0_data, rsp0_error);
            if (rsp1_valid) begin
                rsp1_cnt++;
                check_rsp(1'b1, rsp1_data, rsp1_error);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] order;
        int         grants;
        int         cnt_before;

        reset = 1'b0;
        req0_valid = 0; req0_addr = 0; req0_write = 0; req0_size = 0; req0_wdata = 0;
        req1_valid = 0; req1_addr = 0; req1_write = 0; req1_size = 0; req1_wdata = 0;
        hready = 1'b1; hresp = 1'b0; auto_slave = 1'b0; man_rdata = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_htrans", 32'(htrans), 32'd0);
        chk("reset_haddr", haddr, 32'd0);
        chk("reset_hwdata", hwdata, 32'd0);
        chk("reset_ctrl", 32'({hwrite, hsize, req0_ready, req1_ready, rsp0_valid,
                               rsp1_valid, rsp0_error, rsp1_error}), 32'd0);
        chk("reset_rdata", rsp0_data | rsp1_data, 32'd0);
        reset = 1'b1;
        tick();

        // Single fetch read
        req1_valid = 1; req1_addr = 32'h100; req1_write = 0; req1_size = 2;
        man_rdata = 32'h0050_0093;
        sb.push_back('{1'b1, 32'h0050_0093, 1'b0});
        tick();
        chk("t1_ready", 32'(req1_ready), 32'd1);
        chk("t1_htrans", 32'(htrans), 32'h2);
        chk("t1_haddr", haddr, 32'h100);
        chk("t1_hsize", 32'(hsize), 32'd2);
        req1_valid = 0;
        tick();
        chk("t1_dphase_htrans", 32'(htrans), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(rsp1_valid), 32'd1);
        tick();

        // Data write with wait states
        req0_valid = 1; req0_addr = 32'h2000; req0_write = 1; req0_size = 2;
        req0_wdata = 32'hDEAD_BEEF; hready = 0;
        sb.push_back('{1'b0, 32'd0, 1'b0});
        tick();
        chk("t2_ready", 32'(req0_ready), 32'd1);
        chk("t2_hwrite", 32'(hwrite), 32'd1);
        req0_valid = 0;
        tick();
        chk("t2_haddr_w1", haddr, 32'h2000);
        tick();
        chk("t2_haddr_w2", haddr, 32'h2000);
        chk("t2_htrans_w2", 32'(htrans), 32'h2);
        hready = 1;
        tick();
        chk("t2_hwdata", hwdata, 32'hDEAD_BEEF);
        chk("t2_htrans_dp", 32'(htrans), 32'd0);
        hready = 0;
        tick();
        chk("t2_hwdata_hold", hwdata, 32'hDEAD_BEEF);
        chk("t2_no_early_rsp", 32'(rsp0_valid), 32'd0);
        hready = 1;
        tick();
        chk("t2_rsp_valid", 32'(rsp0_valid), 32'd1);
        tick();

        // Two-cycle ERROR response on a read
        req0_valid = 1; req0_addr = 32'hFFFF_0000; req0_write = 0; req0_size = 1;
        man_rdata = 32'h1234_5678;
        sb.push_back('{1'b0, 32'd0, 1'b1});
        tick();
        chk("t4_hsize", 32'(hsize), 32'd1);
        req0_valid = 0;
        tick();
        hready = 0; hresp = 1;
        tick();
        chk("t4_rsp_wait", 32'(rsp0_valid), 32'd0);
        hready = 1;
        tick();
        chk("t4_rsp_valid", 32'(rsp0_valid), 32'd1);
        hresp = 0;
        tick();
        chk("t4_single_pulse", 32'(rsp0_valid), 32'd0);

        // Reset during the data phase of a fetch read
        req1_valid = 1; req1_addr = 32'h400; req1_write = 0; req1_size = 2;
        man_rdata = 32'h1111_1111;
        cnt_before = rsp1_cnt;
        tick();
        chk("t5_ready", 32'(req1_ready), 32'd1);
        req1_valid = 0;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_htrans_reset", 32'(htrans), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        req0_valid = 1; req0_addr = 32'h500; req0_write = 0; req0_size = 2;
        man_rdata = 32'h0BAD_F00D;
        sb.push_back('{1'b0, 32'h0BAD_F00D, 1'b0});
        tick();
        chk("t5_ready0", 32'(req0_ready), 32'd1);
        req0_valid = 0;
        tick();
        tick();
        chk("t5_rsp0", 32'(rsp0_valid), 32'd1);
        repeat (3) tick();
        chk("t5_no_rsp1", 32'(rsp1_cnt), 32'(cnt_before));

        // Idle bus
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_idle", 32'({htrans, req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 32'd0);
        end

        // Starvation guard with both ports continuously requesting
        auto_slave = 1;
        hready = 1;
        req0_addr = 32'h1000; req0_write = 0; req0_size = 2;
        req1_addr = 32'h3000; req1_write = 0; req1_size = 2;
        order = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            sb.push_back(order[i] ? '{1'b1, 32'hCAFE_3000, 1'b0}
                                  : '{1'b0, 32'hCAFE_1000, 1'b0});
        end
        req0_valid = 1; req1_valid = 1;
        grants = 0;
        for (int c = 0; c < 300 && grants < 10; c++) begin
            tick();
            if (req0_ready || req1_ready) begin
                chk("t3_grant_order", 32'(req1_ready), 32'(order[grants]));
                chk("t3_ready_excl", 32'(req0_ready & req1_ready), 32'd0);
                grants++;
                if (grants == 10) begin
                    req0_valid = 0; req1_valid = 0;
                end
            end
        end
        chk("t3_grant_count", 32'(grants), 32'd10);
        req0_valid = 0; req1_valid = 0;
        repeat (6) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares the single AHB-Lite master port between two requesters: port 0 = load/store unit (data), port 1 = instruction fetch.
- Accepts word/half/byte requests, runs exactly one transfer at a time (address phase then data phase), and returns read data or an error to the granted requester.
- Sits between the core pipeline and the system bus.
- Fixed priority to data, with a starvation guard that forces a fetch grant after MAX_CONSEC consecutive data grants while fetch waits.

Parameters:
MAX_CONSEC, 4, consecutive port-0 grants allowed while port 1 is pending before port 1 is forced; range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  data request pending; payload held stable until req0_ready
- req0_addr  in  32  byte address
- req0_write  in  1  1 = write, 0 = read
- req0_size  in  2  HSIZE encoding: 0 = byte, 1 = half, 2 = word
- req0_wdata  in  32  write data
- req0_ready  out  1  one-cycle pulse: request accepted
- rsp0_valid  out  1  one-cycle pulse: transfer complete
- rsp0_data  out  32  read data; 0 for writes and errors
- rsp0_error  out  1  bus returned ERROR; valid with rsp0_valid
- req1_valid, req1_addr, req1_write, req1_size, req1_wdata, req1_ready, rsp1_valid, rsp1_data, rsp1_error: same as port 0, for fetch
- haddr  out  32  AHB address
- htrans  out  2  AHB transfer type: 00 IDLE, 10 NONSEQ only
- hwrite  out  1  AHB write
- hsize  out  3  AHB size, zero-extended from reqN_size
- hwdata  out  32  AHB write data, driven during data phase
- hrdata  in  32  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB response: 1 = ERROR

Behaviour:
- Reset (async, reset low):
  - state = IDLE, starve counter = 0.
  - htrans = 00; haddr, hwrite, hsize, hwdata = 0.
  - All reqN_ready, rspN_valid, rspN_error = 0; rspN_data = 0.
  - Reset mid-transfer abandons the transfer. No response is issued.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If no reqN_valid: stay in IDLE, htrans = 00.
  - Otherwise pick a winner (see arbitration). At the edge:
    - latch winner index, addr, write, size, wdata
    - drive haddr, hwrite, hsize; htrans = 10
    - pulse reqW_ready for one cycle
    - go to ADDR
- ADDR: address phase.
  - Hold haddr, hwrite, hsize and htrans = 10 until hready = 1 is sampled.
  - On that edge: htrans = 00, hwdata = latched wdata, go to DATA.
- DATA: data phase.
  - Hold hwdata.
  - When hready = 1 is sampled, at that edge pulse rspW_valid for one cycle:
    - rspW_error = hresp
    - rspW_data = hrdata for an error-free read, else 0
  - Go to IDLE.
  - hresp while hready = 0 (first cycle of the two-cycle ERROR) is ignored; only the completing cycle is sampled.
- Arbitration, evaluated only in IDLE:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant 1 if starve counter == MAX_CONSEC, else grant 0.
  - Starve counter, updated on each grant:
    - port-0 grant with req1_valid high: +1, saturating at MAX_CONSEC
    - port-0 grant with req1_valid low: cleared to 0
    - port-1 grant: cleared to 0
- Latency with hready held 1:
  - req sampled at edge E0 → ready pulse and htrans = 10 in cycle E0+1.
  - Data phase in E0+2; rsp_valid in E0+3.
  - Minimum 3 cycles per transfer, no overlap.
- Requesters may hold reqN_valid through their own ready pulse. The arbiter ignores reqN_valid outside IDLE, and the IDLE after DATA re-arbitrates.
- Never more than one outstanding transfer; never simultaneous rsp0_valid and rsp1_valid.
- Unaligned addresses pass through unchanged; alignment errors are the slave's responsibility.

Test Plan:
- Single fetch read: req1 addr 0x00000100, hready = 1, hrdata = 0x00500093 → req1_ready at cycle 1, htrans = 10/haddr = 0x100 at cycle 1, rsp1_valid at cycle 3 with rsp1_data = 0x00500093, rsp1_error = 0.
- Data write with wait states: req0 write addr 0x2000, wdata 0xDEADBEEF, size 2; hready low 2 cycles in ADDR and 1 cycle in DATA → haddr held stable, hwdata = 0xDEADBEEF in data phase, rsp0_valid once after 6 cycles with data 0.
- Starvation guard, MAX_CONSEC = 4, both valid continuously → grant order 0,0,0,0,1,0,0,0,0,1; no rsp1 wait exceeds 5 transfers.
- Error response: read addr 0xFFFF0000, slave drives hresp = 1/hready = 0 then hresp = 1/hready = 1 → rsp_error = 1, rsp_data = 0, single rsp_valid, FSM back in IDLE.
- Reset asserted in DATA of a port-1 read → htrans = 00, no rsp1_valid ever; after reset release a new req0 read completes normally in 3 cycles.
- Idle bus: no requests for 20 cycles → htrans stays 00, no ready/rsp pulses, starve counter stays 0.
